uart_seq_ctrl: RTL and testbench
================================

// Module: uart_seq_ctrl
// PURPOSE
//  Hardware sequencer for the serial transceiver's operand/result exchange. Detects an operand
//  pair (a,b) from the transceiver, latches it, and interrupts the CPU. It then accepts the
//  8-bit result over the peripheral bus and drives a stretched tx_en so the slower transceiver
//  clock samples it. Sits beside the peripheral block on the same rd/wr/addr/wdata/rdata bus,
//  in the clk domain.
// PARAMETERS
//  BASE_ADDR   32'h40000030  word-aligned base of this block's 4 registers
//  TX_HOLD     16            clk cycles tx_en stays high per transmit (>=2)
//  TIMEOUT     65535         clk cycles to wait for RESULT before abandoning; 0 = never
// PORTS
//  clk       in   1   system clock (single clock)
//  reset     in   1   synchronous, active-high reset
//  rd        in   1   bus read strobe
//  wr        in   1   bus write strobe
//  addr      in   32  bus address
//  wdata     in   32  bus write data
//  rdata     out  32  bus read data, combinational; 0 when rd=0 or address unmapped
//  rx_ready  in   1   transceiver operand-pair-valid, asynchronous (transceiver clock)
//  rx_a      in   8   transceiver operand a (stable while rx_ready high)
//  rx_b      in   8   transceiver operand b
//  result    out  8   byte to transmit, to transceiver
//  tx_en     out  1   transmit request, to transceiver
//  irqout    out  1   interrupt to CPU (level)
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   +0x0 CTRL   RW  [0] enable, [1] irq_en
//   +0x4 STATUS RO  [2:0] state, [3] pending, [4] overrun, [5] timeout; writing +0x4 with
//                  bit4/bit5 set clears that flag (W1C)
//   +0x8 OPS    RO  {16'b0, a_lat, b_lat}
//   +0xC RESULT WO  [7:0] result; accepted only in WAIT_RES
//  Reset: CTRL=0, flags=0, a_lat=b_lat=0, result=0, tx_en=0, irqout=0, state=IDLE.
//  rx_ready: 2-flop synchronizer, then rising-edge detect (edge = sync & ~sync_d).
//   Latency from rx_ready to edge is 2-3 clk.
//  FSM:
//   IDLE     on edge & enable -> LATCH
//   LATCH    a_lat<=rx_a, b_lat<=rx_b, pending<=1 -> WAIT_RES (1 cycle)
//   WAIT_RES tmo counter runs; RESULT write -> result<=wdata[7:0], pending<=0 -> SEND;
//            count==TIMEOUT-1 (TIMEOUT!=0) -> timeout<=1, pending<=0 -> IDLE
//   SEND     tx_en=1 for exactly TX_HOLD cycles -> GAP
//   GAP      tx_en=0; wait until synced rx_ready==0 -> IDLE
//  irqout = pending & irq_en (registered outputs only, no combinational path from bus).
//  Boundaries:
//   - Edge in any state other than IDLE: overrun<=1; operands not relatched.
//   - Edge and RESULT write in the same cycle (WAIT_RES): write wins, overrun<=1.
//   - RESULT write outside WAIT_RES: ignored; no flag change.
//   - CTRL write with enable=0 in any state: next state IDLE, tx_en<=0, pending<=0,
//     counters cleared. Flags kept.
//   - TIMEOUT counter: 16..32 bits as needed, cleared on WAIT_RES entry, no wrap.
//   - W1C and flag set in the same cycle: set wins.
//   - reset mid-SEND: tx_en low on the next edge; all state as reset values.
// STRUCTURE
//  Shared package/header: register offsets, FSM state encodings
//   (IDLE=0, LATCH=1, WAIT_RES=2, SEND=3, GAP=4), STATUS bit positions.
//  One natural sub-module: sync_edge (2-flop synchronizer + rising-edge pulse), reusable for
//   the switch inputs. Everything else in a single module.
// TESTING
//  1 enable=1, irq_en=1; rx_ready 0->1 with a=8'h12, b=8'h34 -> within 4 clk irqout=1,
//    OPS reads 32'h00001234, STATUS[2:0]=2.
//  2 From 1, write RESULT=8'h46 -> result=8'h46; tx_en high exactly TX_HOLD clk; irqout=0.
//    Drop rx_ready -> state IDLE.
//  3 Second rx_ready edge while in SEND -> STATUS[4]=1; OPS unchanged.
//    Write STATUS 32'h10 -> STATUS[4]=0.
//  4 TIMEOUT=8 build; edge, no RESULT -> after 8 clk in WAIT_RES: STATUS[5]=1, irqout=0,
//    state IDLE.
//  5 CTRL=0 written mid-SEND -> tx_en=0 next cycle, state IDLE.
//    RESULT write in IDLE -> result unchanged.
//  6 Assert reset 1 cycle mid-WAIT_RES -> all outputs and registers at reset values;
//    rd of unmapped addr -> rdata=0.

Source files
------------

// File: rtl/uart_seq_ctrl_pkg.sv
// Shared definitions for the transceiver operand/result sequencer:
// FSM encodings, register offsets and register bit positions.
package uart_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_SEND     = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  // Word index (offset[3:2]) of each register inside the block
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_OPS    = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_IRQ_BIT = 1;

  localparam int ST_PEND_BIT = 3;
  localparam int ST_OVR_BIT  = 4;
  localparam int ST_TMO_BIT  = 5;

  function automatic logic [31:0] status_word(input state_t s, input logic pend,
                                              input logic ovr, input logic tmo);
    return {26'b0, tmo, ovr, pend, s};
  endfunction

endpackage

// File: rtl/uart_seq_ctrl_sync.sv
// Two-flop synchronizer with rising-edge pulse; W independent bits so the
// same block can serve a bank of switch inputs.
module uart_seq_ctrl_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta, sync_q, sync_d;

  // Metastability chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= '0;
      sync_q <= '0;
      sync_d <= '0;
    end else begin
      meta   <= din;
      sync_q <= meta;
      sync_d <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~sync_d;

endmodule

// File: rtl/uart_seq_ctrl.sv
// Operand/result sequencer: catches an operand pair from the transceiver,
// interrupts the CPU, takes the result byte over the bus and holds tx_en
// long enough for the slower transceiver clock to see it.
module uart_seq_ctrl
  import uart_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h40000030,
  parameter int unsigned TX_HOLD   = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx_ready,
  input  logic [7:0]  rx_a,
  input  logic [7:0]  rx_b,
  output logic [7:0]  result,
  output logic        tx_en,
  output logic        irqout
);

  localparam int CW = (TIMEOUT > 32'hFFFF) ? 32 : 16;
  localparam int HW = $clog2(TX_HOLD + 1);
  localparam logic [CW-1:0] TMO_LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(TX_HOLD - 1);

  state_t        state, state_nxt;
  logic [1:0]    ctrl, ctrl_d;
  logic          pending, pend_d, overrun, ovr_d, timeout, tmo_d;
  logic [7:0]    a_lat, b_lat;
  logic [CW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;
  logic          latch_op, take_res, tmo_hit;
  logic          rx_sync, rx_edge;

  uart_seq_ctrl_sync #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx_ready),
    .sync  (rx_sync),
    .rise  (rx_edge)
  );

  // Address decode relative to the block base; only word-aligned hits count
  logic [31:0] off;
  logic        in_blk, wr_ctrl, wr_status, wr_result;
  assign off       = addr - BASE_ADDR;
  assign in_blk    = (off[31:4] == '0) && (off[1:0] == 2'b00);
  assign wr_ctrl   = wr && in_blk && (off[3:2] == REG_CTRL);
  assign wr_status = wr && in_blk && (off[3:2] == REG_STATUS);
  assign wr_result = wr && in_blk && (off[3:2] == REG_RESULT);

  logic unused_ok;
  assign unused_ok = ^wdata[31:8];

  // Next state, control strobes and next flag values
  always_comb begin
    state_nxt = state;
    ctrl_d    = wr_ctrl ? wdata[1:0] : ctrl;
    latch_op  = 1'b0;
    take_res  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:     if (rx_edge && ctrl[CTRL_EN_BIT]) state_nxt = ST_LATCH;
      ST_LATCH: begin
        latch_op  = 1'b1;
        state_nxt = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (wr_result) begin
          take_res  = 1'b1;
          state_nxt = ST_SEND;
        end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SEND:     if (hold_cnt == HOLD_LAST) state_nxt = ST_GAP;
      ST_GAP:      if (!rx_sync) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    // Disabling aborts whatever is in flight; sticky flags survive
    if (wr_ctrl && !wdata[CTRL_EN_BIT]) begin
      state_nxt = ST_IDLE;
      latch_op  = 1'b0;
      take_res  = 1'b0;
      tmo_hit   = 1'b0;
    end
    pend_d = pending;
    if (latch_op) pend_d = 1'b1;
    if (take_res || tmo_hit || (wr_ctrl && !wdata[CTRL_EN_BIT])) pend_d = 1'b0;
    // W1C first so a same-cycle set takes priority
    ovr_d = overrun;
    if (wr_status && wdata[ST_OVR_BIT]) ovr_d = 1'b0;
    if (rx_edge && state != ST_IDLE) ovr_d = 1'b1;
    tmo_d = timeout;
    if (wr_status && wdata[ST_TMO_BIT]) tmo_d = 1'b0;
    if (tmo_hit) tmo_d = 1'b1;
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      a_lat    <= '0;
      b_lat    <= '0;
      result   <= '0;
      tx_en    <= 1'b0;
      irqout   <= 1'b0;
      tmo_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ctrl    <= ctrl_d;
      pending <= pend_d;
      overrun <= ovr_d;
      timeout <= tmo_d;
      if (latch_op) begin
        a_lat <= rx_a;
        b_lat <= rx_b;
      end
      if (take_res) result <= wdata[7:0];
      tx_en  <= (state_nxt == ST_SEND);
      irqout <= pend_d & ctrl_d[CTRL_IRQ_BIT];
      // Counters restart on every entry and saturate rather than wrap
      if (state == ST_WAIT_RES && state_nxt == ST_WAIT_RES)
        tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      if (state == ST_SEND && state_nxt == ST_SEND)
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
    end
  end

  // Combinational read mux; RESULT is write-only and reads as zero
  always_comb begin
    rdata = '0;
    if (rd && in_blk) begin
      case (off[3:2])
        REG_CTRL:   rdata = {30'b0, ctrl};
        REG_STATUS: rdata = status_word(state, pending, overrun, timeout);
        REG_OPS:    rdata = {16'b0, a_lat, b_lat};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_seq_ctrl.sv
// Directed bench: the driver queues the expected response for every read or
// probe it issues; a negedge monitor pops and compares in order.
module tb_uart_seq_ctrl;

  localparam logic [31:0] BASE     = 32'h40000030;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_OPS    = BASE + 32'h8;
  localparam logic [31:0] A_RESULT = BASE + 32'hC;
  localparam int HOLD = 6;

  localparam int SEL_RDATA = 0, SEL_IRQ = 1, SEL_TX = 2, SEL_RES = 3, SEL_TXCNT = 4;

  logic        clk = 0, reset = 1, rd = 0, wr = 0, rx_ready = 0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [7:0]  rx_a = '0, rx_b = '0, result;
  logic        tx_en, irqout;

  uart_seq_ctrl #(.BASE_ADDR(BASE), .TX_HOLD(HOLD), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rx_ready(rx_ready), .rx_a(rx_a), .rx_b(rx_b),
    .result(result), .tx_en(tx_en), .irqout(irqout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic chk = 0, done = 0, fin = 0, tx_prev = 0;
  int   total = 0, bad = 0, txcnt = 0;
  logic [31:0] act;

  // Length of the most recent tx_en pulse, in clk cycles
  always @(negedge clk) begin
    if (tx_en) txcnt <= tx_prev ? txcnt + 1 : 1;
    tx_prev <= tx_en;
  end

  // Monitor: compare whatever the driver is probing against the queue head
  always @(negedge clk) begin
    if (rd || chk) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_probe: no expectation queued, rdata=%h", rdata);
      end else begin
        e = q.pop_front();
        case (e.sel)
          SEL_RDATA: act = rdata;
          SEL_IRQ:   act = {31'b0, irqout};
          SEL_TX:    act = {31'b0, tx_en};
          SEL_RES:   act = {24'b0, result};
          default:   act = txcnt;
        endcase
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
    if (done && !fin) begin
      fin = 1;
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL queue_drain: got %0d leftover want 0", q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] x, input string n);
    exp_t t;
    t.name = n; t.sel = SEL_RDATA; t.exp = x;
    q.push_back(t);
    addr = a; rd = 1;
    tick();
    rd = 0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1;
    tick();
    wr = 0;
  endtask

  task automatic probe(input int s, input logic [31:0] x, input string n);
    exp_t t;
    t.name = n; t.sel = s; t.exp = x;
    q.push_back(t);
    chk = 1;
    tick();
    chk = 0;
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    rx_a = a; rx_b = b; rx_ready = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 0;
    // reset values
    bus_rd(A_CTRL,   32'h0, "rst_ctrl");
    bus_rd(A_STATUS, 32'h0, "rst_status");
    bus_rd(A_OPS,    32'h0, "rst_ops");
    probe(SEL_IRQ, 0, "rst_irq");
    probe(SEL_TX,  0, "rst_tx");
    probe(SEL_RES, 0, "rst_result");
    bus_wr(A_CTRL, 32'h3);
    bus_rd(A_CTRL, 32'h3, "ctrl_rw");

    // 1: operand pair -> irq within 4 clk, WAIT_RES
    pair(8'h12, 8'h34);
    repeat (4) tick();
    probe(SEL_IRQ, 1, "t1_irq");
    bus_rd(A_OPS,    32'h00001234, "t1_ops");
    bus_rd(A_STATUS, 32'h0000000A, "t1_status");

    // 2: result write -> SEND for HOLD cycles, then GAP until rx_ready drops
    bus_wr(A_RESULT, 32'h46);
    probe(SEL_RES, 8'h46, "t2_result");
    probe(SEL_IRQ, 0, "t2_irq");
    repeat (HOLD) tick();
    probe(SEL_TXCNT, HOLD, "t2_tx_len");
    bus_rd(A_STATUS, 32'h4, "t2_gap");
    rx_ready = 0;
    repeat (4) tick();
    bus_rd(A_STATUS, 32'h0, "t2_idle");

    // 3: second edge during SEND -> overrun, operands held, W1C clears
    pair(8'h56, 8'h78);
    repeat (4) tick();
    bus_wr(A_RESULT, 32'h9A);
    rx_ready = 0;
    tick(); tick();
    pair(8'hAA, 8'hBB);
    repeat (8) tick();
    bus_rd(A_OPS,    32'h00005678, "t3_ops_kept");
    bus_rd(A_STATUS, 32'h14, "t3_overrun");
    bus_wr(A_STATUS, 32'h10);
    bus_rd(A_STATUS, 32'h04, "t3_w1c");
    probe(SEL_TXCNT, HOLD, "t3_tx_len");
    probe(SEL_RES, 8'h9A, "t3_result");
    rx_ready = 0;
    repeat (4) tick();

    // 4: no result -> timeout after 8 clk in WAIT_RES
    pair(8'h01, 8'h02);
    repeat (4) tick();
    repeat (7) tick();
    bus_rd(A_STATUS, 32'h0A, "t4_last_wait");
    bus_rd(A_STATUS, 32'h20, "t4_timeout");
    probe(SEL_IRQ, 0, "t4_irq");
    bus_wr(A_STATUS, 32'h20);
    bus_rd(A_STATUS, 32'h0, "t4_w1c");
    rx_ready = 0;
    repeat (4) tick();

    // 5: disable mid-SEND, then result write in IDLE is ignored
    pair(8'h11, 8'h22);
    repeat (4) tick();
    bus_wr(A_RESULT, 32'h5A);
    tick(); tick();
    bus_wr(A_CTRL, 32'h0);
    probe(SEL_TX, 0, "t5_tx_off");
    bus_rd(A_STATUS, 32'h0, "t5_idle");
    bus_wr(A_RESULT, 32'hFF);
    probe(SEL_RES, 8'h5A, "t5_result_kept");
    bus_wr(A_CTRL, 32'h3);
    rx_ready = 0;
    repeat (4) tick();

    // 6: reset mid-WAIT_RES, plus rd=0 and unmapped reads
    pair(8'h33, 8'h44);
    repeat (4) tick();
    addr = A_OPS;
    probe(SEL_RDATA, 32'h0, "t6_rd_low");
    bus_rd(A_OPS, 32'h00003344, "t6_ops");
    reset = 1;
    tick();
    reset = 0;
    probe(SEL_IRQ, 0, "t6_irq");
    probe(SEL_TX,  0, "t6_tx");
    probe(SEL_RES, 0, "t6_result");
    bus_rd(A_CTRL,   32'h0, "t6_ctrl");
    bus_rd(A_STATUS, 32'h0, "t6_status");
    bus_rd(A_OPS,    32'h0, "t6_ops");
    bus_rd(BASE + 32'h10, 32'h0, "t6_unmapped");
    bus_rd(A_RESULT, 32'h0, "t6_result_wo");
    rx_ready = 0;

    done = 1;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
